control_estados_mascota: RTL and testbench
==========================================

Name: control_estados_mascota

Overview:
Top-level pet-state scheduler for the virtual-pet FPGA design. Monitors the four 2-bit need levels (animo, descanso, energia, medicina) produced by the primitive mode meters and selects one displayed pet state using fixed priority and a minimum dwell time. Gates which meters may accept user input (activo_comida, activo_medicina). Owns the test mode (state sweep) and the absorbing death state.

Parameters:
UMBRAL, 1, a level <= UMBRAL counts as a need (valid 0..2)
MIN_DWELL, 5000000, minimum cycles a non-ENFERMO state is held before another change (>=1)
DEATH_TIME, 50000000, consecutive cycles with all four levels == 0 before MUERTO (>=1)
TEST_PERIOD, 25000000, cycles per step in the test sweep (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset (debounced Senal_Reset)
test_pulse  in  1  one-cycle debounced test-button pulse
nivel_animo  in  2  animo meter level, 3=full, 0=empty
nivel_descanso  in  2  descanso meter level
nivel_energia  in  2  energia meter level
nivel_medicina  in  2  medicina meter level
estado  out  3  0 NEUTRAL, 1 TRISTE, 2 CANSADO, 3 HAMBRIENTO, 4 ENFERMO, 5 MUERTO
modo_test  out  1  high while the test sweep is running
activo_comida  out  1  enables the energia meter input
activo_medicina  out  1  enables the medicina meter input
cambio_estado  out  1  one-cycle pulse when estado changes value

Behaviour:
- Reset has priority over all other inputs. It sets estado=NEUTRAL, modo_test=0, activo_*=0, cambio_estado=0, and clears the dwell, death and test counters.
- The candidate state is computed combinationally every cycle. Priority order: ENFERMO (medicina<=UMBRAL) > HAMBRIENTO (energia) > CANSADO (descanso) > TRISTE (animo) > NEUTRAL.
- Normal mode, each clock edge:
  - The dwell counter decrements, saturating at 0.
  - If candidate==ENFERMO and estado!=ENFERMO: switch immediately, ignoring dwell.
  - Otherwise, if candidate!=estado and dwell==0: switch.
  - On any switch, dwell reloads to MIN_DWELL-1.
  - Latency from a level change to estado is 1 cycle when dwell permits.
- Death counter:
  - Increments each cycle in normal mode while all four levels == 0.
  - Clears on any nonzero level.
  - On the edge where the count reaches DEATH_TIME, estado becomes MUERTO. This overrides the candidate and dwell.
- MUERTO is absorbing: only reset leaves it. In MUERTO, test_pulse and all levels are ignored.
- test_pulse in any state except MUERTO toggles modo_test.
- Entering test mode:
  - estado=NEUTRAL, test counter=0, death counter cleared and frozen.
  - estado steps 0->1->...->5->0 every TEST_PERIOD cycles.
  - In test mode, MUERTO is display-only and not absorbing.
- Exiting test mode: estado=NEUTRAL, dwell reloads to MIN_DWELL-1, death counter=0. Normal evaluation resumes the next cycle.
- If test_pulse coincides with a candidate change, the toggle wins and the candidate is ignored that cycle.
- activo_comida = !modo_test && estado!=MUERTO && nivel_energia!=3.
- activo_medicina = !modo_test && estado==ENFERMO.
- Both activo outputs are registered and computed from the next-state value, so they align with estado in the same cycle.
- cambio_estado is registered. It is high for exactly the cycle after estado takes a new value, covering normal, test-step, test-entry/exit and MUERTO transitions. It stays low if estado is rewritten with the same value.
- All counters are sized to $clog2(param+1) and never wrap.

Test Plan (MIN_DWELL=4, DEATH_TIME=8, TEST_PERIOD=3, UMBRAL=1):
- Reset, then all levels=3 -> estado=0, activo_comida=0, activo_medicina=0, modo_test=0, cambio_estado=0.
- Animo drops to 1 -> estado=1 one cycle later with a cambio_estado pulse. Energia drops to 0 two cycles later -> estado holds 1 until dwell expires (4 cycles after the first change), then becomes 3; activo_comida=1.
- From TRISTE with dwell=3, medicina drops to 1 -> estado=4 next cycle (preemption); activo_medicina=1.
- All levels=0 for 8 cycles -> estado=5, activo_*=0. Levels then restored to 3 and a test_pulse applied -> estado stays 5; a reset pulse -> estado=0.
- test_pulse -> modo_test=1, estado sweeps 0,1,2,3,4,5,0 every 3 cycles, with a cambio_estado pulse each step. Second test_pulse -> modo_test=0, estado=0, dwell reloaded.
- Reset asserted mid test sweep, together with test_pulse -> all outputs return to their reset values on the next edge, and modo_test=0.

Source files
------------

// File: rtl/control_estados_mascota_if.sv
// Level/command inputs and displayed-state outputs of the pet-state scheduler.
interface control_estados_mascota_if;
  logic       test_pulse;
  logic [1:0] nivel_animo;
  logic [1:0] nivel_descanso;
  logic [1:0] nivel_energia;
  logic [1:0] nivel_medicina;
  logic [2:0] estado;
  logic       modo_test;
  logic       activo_comida;
  logic       activo_medicina;
  logic       cambio_estado;

  // Environment side: drives levels and the test button, observes the pet.
  modport master (
    output test_pulse, nivel_animo, nivel_descanso, nivel_energia, nivel_medicina,
    input  estado, modo_test, activo_comida, activo_medicina, cambio_estado
  );

  // Scheduler side.
  modport slave (
    input  test_pulse, nivel_animo, nivel_descanso, nivel_energia, nivel_medicina,
    output estado, modo_test, activo_comida, activo_medicina, cambio_estado
  );
endinterface

// File: rtl/control_estados_mascota.sv
// Pet-state scheduler: priority selection with minimum dwell, death detection,
// test sweep and meter input gating.
module control_estados_mascota #(
  parameter int unsigned UMBRAL      = 1,
  parameter int unsigned MIN_DWELL   = 5000000,
  parameter int unsigned DEATH_TIME  = 50000000,
  parameter int unsigned TEST_PERIOD = 25000000
) (
  input  logic                           clk,
  input  logic                           reset,
  control_estados_mascota_if.slave       mascota
);

  localparam int unsigned DWELL_W = $clog2(MIN_DWELL + 1);
  localparam int unsigned DEATH_W = $clog2(DEATH_TIME + 1);
  localparam int unsigned TEST_W  = $clog2(TEST_PERIOD + 1);

  localparam logic [1:0]         UMB          = 2'(UMBRAL);
  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(MIN_DWELL - 1);
  localparam logic [DEATH_W-1:0] DEATH_LAST   = DEATH_W'(DEATH_TIME - 1);
  localparam logic [DEATH_W-1:0] DEATH_FULL   = DEATH_W'(DEATH_TIME);
  localparam logic [TEST_W-1:0]  TEST_LAST    = TEST_W'(TEST_PERIOD - 1);

  typedef enum logic [2:0] {
    NEUTRAL    = 3'd0,
    TRISTE     = 3'd1,
    CANSADO    = 3'd2,
    HAMBRIENTO = 3'd3,
    ENFERMO    = 3'd4,
    MUERTO     = 3'd5
  } estado_t;

  estado_t             estado_q, estado_d;
  logic                modo_q, modo_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DEATH_W-1:0]  death_q, death_d;
  logic [TEST_W-1:0]   test_q, test_d;
  logic                comida_q, comida_d;
  logic                medicina_q, medicina_d;
  logic                cambio_q, cambio_d;

  estado_t             candidato_c;
  logic                todos_cero_c;
  logic                cambia_c;

  // Candidate state from the need levels, highest need first.
  always_comb begin
    candidato_c = NEUTRAL;
    if (mascota.nivel_medicina <= UMB)      candidato_c = ENFERMO;
    else if (mascota.nivel_energia <= UMB)  candidato_c = HAMBRIENTO;
    else if (mascota.nivel_descanso <= UMB) candidato_c = CANSADO;
    else if (mascota.nivel_animo <= UMB)    candidato_c = TRISTE;
  end

  assign todos_cero_c = (mascota.nivel_animo == 2'd0) && (mascota.nivel_descanso == 2'd0) &&
                        (mascota.nivel_energia == 2'd0) && (mascota.nivel_medicina == 2'd0);

  // Next-state: dead hold, test toggle, test sweep, then normal scheduling.
  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    dwell_d  = (dwell_q != '0) ? dwell_q - DWELL_W'(1) : '0;
    death_d  = death_q;
    test_d   = test_q;
    cambia_c = 1'b0;

    if (!modo_q && (estado_q == MUERTO)) begin
      // Absorbing: only reset leaves.
      estado_d = MUERTO;
    end else if (mascota.test_pulse) begin
      modo_d   = !modo_q;
      estado_d = NEUTRAL;
      test_d   = '0;
      death_d  = '0;
      if (modo_q) dwell_d = DWELL_RELOAD;
    end else if (modo_q) begin
      // Sweep through every state, MUERTO included, then wrap.
      if (test_q == TEST_LAST) begin
        test_d   = '0;
        estado_d = (estado_q == MUERTO) ? NEUTRAL : estado_t'(estado_q + 3'd1);
      end else begin
        test_d = test_q + TEST_W'(1);
      end
    end else begin
      death_d = todos_cero_c ? death_q + DEATH_W'(1) : '0;
      if (todos_cero_c && (death_q == DEATH_LAST)) begin
        estado_d = MUERTO;
        death_d  = DEATH_FULL;
      end else if ((candidato_c == ENFERMO) && (estado_q != ENFERMO)) begin
        estado_d = ENFERMO;
        cambia_c = 1'b1;
      end else if ((candidato_c != estado_q) && (dwell_q == '0)) begin
        estado_d = candidato_c;
        cambia_c = 1'b1;
      end
      if (cambia_c) dwell_d = DWELL_RELOAD;
    end

    comida_d   = !modo_d && (estado_d != MUERTO) && (mascota.nivel_energia != 2'd3);
    medicina_d = !modo_d && (estado_d == ENFERMO);
    cambio_d   = (estado_d != estado_q);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= NEUTRAL;
      modo_q     <= 1'b0;
      dwell_q    <= '0;
      death_q    <= '0;
      test_q     <= '0;
      comida_q   <= 1'b0;
      medicina_q <= 1'b0;
      cambio_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      modo_q     <= modo_d;
      dwell_q    <= dwell_d;
      death_q    <= death_d;
      test_q     <= test_d;
      comida_q   <= comida_d;
      medicina_q <= medicina_d;
      cambio_q   <= cambio_d;
    end
  end

  assign mascota.estado          = estado_q;
  assign mascota.modo_test       = modo_q;
  assign mascota.activo_comida   = comida_q;
  assign mascota.activo_medicina = medicina_q;
  assign mascota.cambio_estado   = cambio_q;

endmodule

// File: tb/tb_control_estados_mascota.sv
// Randomized bench for the pet-state scheduler against a cycle-count model.
module tb_control_estados_mascota;

  localparam int UMBRAL      = 1;
  localparam int MIN_DWELL   = 4;
  localparam int DEATH_TIME  = 8;
  localparam int TEST_PERIOD = 3;

  logic clk;
  logic reset;

  control_estados_mascota_if mascota ();

  control_estados_mascota #(
    .UMBRAL      (UMBRAL),
    .MIN_DWELL   (MIN_DWELL),
    .DEATH_TIME  (DEATH_TIME),
    .TEST_PERIOD (TEST_PERIOD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mascota (mascota.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: expressed as edge counts rather than down-counters.
  int m_cyc       = 0;
  int m_est       = 0;
  int m_test      = 0;
  int m_zero_run  = 0;
  int m_last_sw   = -1000000;
  int m_test_from = 0;
  int m_comida    = 0;
  int m_medicina  = 0;
  int m_cambio    = 0;

  // Single comparison point.
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic int need(input logic [1:0] lvl);
    return (int'(lvl) <= UMBRAL) ? 1 : 0;
  endfunction

  // One clock edge of the behavioural pet.
  task automatic model_step(input logic r, input logic tp,
                            input logic [1:0] a, input logic [1:0] d,
                            input logic [1:0] e, input logic [1:0] m);
    int old;
    int cand;
    old = m_est;
    m_cyc++;
    if (r) begin
      m_est = 0; m_test = 0; m_zero_run = 0; m_last_sw = -1000000;
      m_comida = 0; m_medicina = 0; m_cambio = 0;
    end else begin
      if (m_test == 0 && m_est == 5) begin
        m_est = 5;
      end else if (tp) begin
        m_test = 1 - m_test;
        m_est = 0;
        m_zero_run = 0;
        if (m_test == 1) m_test_from = m_cyc;
        else m_last_sw = m_cyc;
      end else if (m_test == 1) begin
        m_est = ((m_cyc - m_test_from) / TEST_PERIOD) % 6;
      end else begin
        if (a == 0 && d == 0 && e == 0 && m == 0) m_zero_run++;
        else m_zero_run = 0;
        if (need(m))      cand = 4;
        else if (need(e)) cand = 3;
        else if (need(d)) cand = 2;
        else if (need(a)) cand = 1;
        else              cand = 0;
        if (m_zero_run == DEATH_TIME) begin
          m_est = 5;
        end else if (cand == 4 && m_est != 4) begin
          m_est = 4; m_last_sw = m_cyc;
        end else if (cand != m_est && (m_cyc - m_last_sw) >= MIN_DWELL) begin
          m_est = cand; m_last_sw = m_cyc;
        end
      end
      m_comida   = (m_test == 0 && m_est != 5 && e != 2'd3) ? 1 : 0;
      m_medicina = (m_test == 0 && m_est == 4) ? 1 : 0;
      m_cambio   = (m_est != old) ? 1 : 0;
    end
  endtask

  // Drive one vector, clock it, then compare on the falling edge.
  task automatic apply(input logic r, input logic tp,
                       input logic [1:0] a, input logic [1:0] d,
                       input logic [1:0] e, input logic [1:0] m);
    reset = r;
    mascota.test_pulse     = tp;
    mascota.nivel_animo    = a;
    mascota.nivel_descanso = d;
    mascota.nivel_energia  = e;
    mascota.nivel_medicina = m;
    @(posedge clk);
    model_step(r, tp, a, d, e, m);
    @(negedge clk);
    check("estado",          8'(mascota.estado),          8'(m_est));
    check("modo_test",       8'(mascota.modo_test),       8'(m_test));
    check("activo_comida",   8'(mascota.activo_comida),   8'(m_comida));
    check("activo_medicina", 8'(mascota.activo_medicina), 8'(m_medicina));
    check("cambio_estado",   8'(mascota.cambio_estado),   8'(m_cambio));
  endtask

  logic [1:0] lv [4];
  int         zero_mode;

  initial begin
    reset = 1'b1;
    mascota.test_pulse = 1'b0;
    mascota.nivel_animo = 2'd3; mascota.nivel_descanso = 2'd3;
    mascota.nivel_energia = 2'd3; mascota.nivel_medicina = 2'd3;
    @(negedge clk);

    // Reset with everything full.
    apply(1, 0, 3, 3, 3, 3);
    apply(1, 0, 3, 3, 3, 3);
    check("reset_estado", 8'(mascota.estado), 8'd0);
    check("reset_comida", 8'(mascota.activo_comida), 8'd0);
    apply(0, 0, 3, 3, 3, 3);
    apply(0, 0, 3, 3, 3, 3);

    // Animo drop, then energia drop held off by dwell.
    apply(0, 0, 1, 3, 3, 3);
    check("plan_triste", 8'(mascota.estado), 8'd1);
    check("plan_triste_pulse", 8'(mascota.cambio_estado), 8'd1);
    apply(0, 0, 1, 3, 3, 3);
    apply(0, 0, 1, 3, 0, 3);
    apply(0, 0, 1, 3, 0, 3);
    check("plan_dwell_hold", 8'(mascota.estado), 8'd1);
    apply(0, 0, 1, 3, 0, 3);
    check("plan_hambriento", 8'(mascota.estado), 8'd3);
    check("plan_comida", 8'(mascota.activo_comida), 8'd1);

    // Back to TRISTE, then medicina preempts with dwell still loaded.
    for (int i = 0; i < 4; i++) apply(0, 0, 1, 3, 3, 3);
    check("plan_triste_again", 8'(mascota.estado), 8'd1);
    apply(0, 0, 1, 3, 3, 1);
    check("plan_enfermo", 8'(mascota.estado), 8'd4);
    check("plan_medicina", 8'(mascota.activo_medicina), 8'd1);

    // Starvation to death, which ignores the test button.
    for (int i = 0; i < 7; i++) apply(0, 0, 0, 0, 0, 0);
    check("plan_not_dead_yet", 8'(mascota.estado), 8'd4);
    apply(0, 0, 0, 0, 0, 0);
    check("plan_muerto", 8'(mascota.estado), 8'd5);
    apply(0, 1, 3, 3, 3, 3);
    apply(0, 0, 3, 3, 3, 3);
    check("plan_dead_absorbing", 8'(mascota.estado), 8'd5);
    apply(1, 0, 3, 3, 3, 3);
    check("plan_revive", 8'(mascota.estado), 8'd0);

    // Full test sweep and exit.
    apply(0, 1, 3, 3, 3, 3);
    check("plan_test_on", 8'(mascota.modo_test), 8'd1);
    for (int i = 0; i < 19; i++) apply(0, 0, 0, 0, 0, 0);
    apply(0, 1, 1, 3, 3, 3);
    check("plan_test_off", 8'(mascota.modo_test), 8'd0);
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 3, 3, 3);

    // Reset together with the button in the middle of a sweep.
    apply(0, 1, 3, 3, 3, 3);
    for (int i = 0; i < 7; i++) apply(0, 0, 3, 3, 3, 3);
    apply(1, 1, 3, 3, 3, 3);
    check("plan_reset_mid_test", 8'(mascota.modo_test), 8'd0);

    // Random soak: slowly drifting levels, starvation bursts, rare buttons/resets.
    for (int k = 0; k < 4; k++) lv[k] = 2'd3;
    zero_mode = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 29) == 0) zero_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) lv[k] = 2'($urandom_range(0, 3));
      if (zero_mode == 1)
        apply(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0), 0, 0, 0, 0);
      else
        apply(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
              lv[0], lv[1], lv[2], lv[3]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
